button_press_classifier: RTL and testbench
==========================================

# button_press_classifier

Classifies debounced button activity into user-level events: short press, double press, long press, and auto-repeat while held. Sits directly downstream of the button debouncer, one instance per front-panel button. It consumes the debouncer's one-cycle press/release pulses and feeds the clock's time-set and mode controller with one-cycle event pulses.

## Interface
- `LONG_CYCLES`, default 100_000_000: hold time that qualifies a long press (1 s at 100 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, default 20_000_000: auto-repeat period once long-held (200 ms); must be ≥ 2.
- `GAP_CYCLES`, default 30_000_000: maximum release-to-second-press gap for a double press (300 ms); 0 disables double-press detection.

Ports:
- `clk` in 1: system clock, 100 MHz; block uses rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `press_pulse` in 1: one-cycle pulse, button became pressed (debounced).
- `release_pulse` in 1: one-cycle pulse, button became released (debounced).
- `short_pulse` out 1: one-cycle pulse, single short press completed.
- `double_pulse` out 1: one-cycle pulse, double press completed.
- `long_pulse` out 1: one-cycle pulse, hold reached `LONG_CYCLES`.
- `repeat_pulse` out 1: one-cycle pulse every `REPEAT_CYCLES` while long-held.
- `held` out 1: level, high in any pressed state.

## Operation
- States: IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND_PRESSED. Single counter `cnt`, width `$clog2` of the largest parameter, cleared on every state transition.
- IDLE: `press_pulse` → PRESSED.
- PRESSED: `cnt` increments. `release_pulse` before `cnt == LONG_CYCLES-1` → WAIT_GAP. If `GAP_CYCLES == 0`, it instead asserts `short_pulse` and goes → IDLE. At `cnt == LONG_CYCLES-1` with no release: `long_pulse`, → LONG_HELD.
- LONG_HELD: at `cnt == REPEAT_CYCLES-1`: `repeat_pulse`, `cnt` cleared, stay. `release_pulse` → IDLE; no short or double event.
- WAIT_GAP: `press_pulse` while `cnt < GAP_CYCLES-1` → SECOND_PRESSED. At `cnt == GAP_CYCLES-1`: `short_pulse`, → IDLE. A press on that same cycle loses: the short is reported and the press is dropped.
- SECOND_PRESSED: `release_pulse` → `double_pulse`, → IDLE. At `cnt == LONG_CYCLES-1` with no release: `short_pulse` for the first click and `long_pulse` on the same cycle, → LONG_HELD.
- `press_pulse` and `release_pulse` both high in one cycle: both ignored; state and `cnt` still advance normally.
- Stray pulses are ignored: a press in a pressed state, or a release in IDLE or WAIT_GAP.
- At most one of `double_pulse`/`repeat_pulse` per cycle. `short_pulse` and `long_pulse` coincide only in the SECOND_PRESSED timeout case.

## Timing
- Reset: state IDLE, `cnt` 0, all outputs 0. Assertion mid-sequence aborts it with no event emitted. First event is possible on the first rising edge after deassertion.
- All outputs are registered. Each event pulse is high for exactly one cycle: the cycle after the edge that samples the triggering input pulse or counter terminal value.
- `held` rises the cycle after `press_pulse` is sampled and falls the cycle after `release_pulse` is sampled. It is 0 in IDLE and WAIT_GAP.
- Long press: `long_pulse` occurs `LONG_CYCLES` cycles after the `held` rise. First `repeat_pulse` follows `REPEAT_CYCLES` cycles later, then periodically.
- Short press is reported `GAP_CYCLES` cycles after release; this is the intentional double-press latency.
- Inputs may originate from a negedge-clocked stage. They are sampled at posedge with a half-cycle margin, so no extra synchronizer is needed.

## Structure
- Shared package `nixie_button_pkg`:
  - state enum `btn_state_t`
  - default timing constants `BTN_LONG_CYCLES`, `BTN_REPEAT_CYCLES`, `BTN_GAP_CYCLES`
- Sub-module `event_timer`: loadable up-counter with clear input and a terminal-match output against a selectable limit. Used for all three intervals.
- FSM and output registers live in `button_press_classifier`.

## Test plan
Benches use small parameters: `LONG_CYCLES=20`, `REPEAT_CYCLES=5`, `GAP_CYCLES=8`.
- Press, release after 5 cycles → `short_pulse` once, 8 cycles after release; no other events; `held` high for 5 cycles.
- Press, release after 4, press after 3, release after 4 → one `double_pulse` the cycle after the second release; no `short_pulse`.
- Press held 32 cycles → `long_pulse` at cycle 20, `repeat_pulse` at 25 and 30; release → no `short_pulse`.
- Click, then second press held 20 cycles → `short_pulse` and `long_pulse` on the same cycle, then repeats every 5.
- `rst_n` low during LONG_HELD and during WAIT_GAP → all outputs 0 immediately, no event after release; simultaneous press+release in IDLE → no state change.
- `GAP_CYCLES=0`: press 5, release → `short_pulse` the cycle after release is sampled.

Source files
------------

// File: rtl/button_press_classifier_pkg.sv
// Shared types and default timing for the front-panel button classifiers.
package nixie_button_pkg;

  // Default intervals at a 100 MHz system clock.
  localparam int BTN_LONG_CYCLES   = 100_000_000;  // 1 s
  localparam int BTN_REPEAT_CYCLES = 20_000_000;   // 200 ms
  localparam int BTN_GAP_CYCLES    = 30_000_000;   // 300 ms

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_GAP,
    SECOND_PRESSED
  } btn_state_t;

  // Which interval the shared timer is currently compared against.
  typedef enum logic [1:0] {
    SEL_LONG,
    SEL_REPEAT,
    SEL_GAP
  } timer_sel_t;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Debouncer-side pulses in, user-level event pulses out.
interface button_press_classifier_if;
  logic press_pulse;
  logic release_pulse;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  // Upstream side: the debouncer drives pulses and observes events.
  modport master (
    output press_pulse, release_pulse,
    input  short_pulse, double_pulse, long_pulse, repeat_pulse, held
  );

  // Classifier side.
  modport slave (
    input  press_pulse, release_pulse,
    output short_pulse, double_pulse, long_pulse, repeat_pulse, held
  );
endinterface

// File: rtl/button_press_classifier_event_timer.sv
// Shared interval timer: up-counter with clear/load and a terminal match
// against one of three limits chosen by the caller.
module event_timer
  import nixie_button_pkg::*;
#(
  parameter int            CW        = 8,
  parameter logic [CW-1:0] LONG_TC   = '0,
  parameter logic [CW-1:0] REPEAT_TC = '0,
  parameter logic [CW-1:0] GAP_TC    = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] loadVal,
  input  timer_sel_t    limitSel,
  output logic          match
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;

  // Count up every cycle; clear wins over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Select the terminal value for the interval being timed.
  always_comb begin
    limit = LONG_TC;
    case (limitSel)
      SEL_LONG:   limit = LONG_TC;
      SEL_REPEAT: limit = REPEAT_TC;
      SEL_GAP:    limit = GAP_TC;
      default:    limit = LONG_TC;
    endcase
  end

  assign match = (cnt == limit);

endmodule

// File: rtl/button_press_classifier.sv
// Turns debounced press/release pulses into short, double, long and
// auto-repeat events. All outputs are registered one-cycle pulses except
// held, which is a level.
//
// state          | meaning
// ---------------+-------------------------------------------------------
// IDLE           | button up, nothing pending
// PRESSED        | first press down, timing toward long press
// LONG_HELD      | long press reported, emitting repeats every period
// WAIT_GAP       | first click released, waiting for a second press
// SECOND_PRESSED | second press down, double on release or long on timeout
//
// A release that lands on the same cycle as a terminal count wins: the
// button is already up, so the hold-based event is not reported.
module button_press_classifier
  import nixie_button_pkg::*;
#(
  parameter int LONG_CYCLES   = BTN_LONG_CYCLES,
  parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES,
  parameter int GAP_CYCLES    = BTN_GAP_CYCLES
) (
  input logic                       clk,
  input logic                       rst_n,
  button_press_classifier_if.slave  bus
);

  localparam int MAX_CYCLES = maxOf3(LONG_CYCLES, REPEAT_CYCLES, GAP_CYCLES);
  localparam int CW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] LONG_TC   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);
  // With GAP_CYCLES == 0 the WAIT_GAP state is never entered.
  localparam logic [CW-1:0] GAP_TC    = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  btn_state_t state, stateNext;
  timer_sel_t timerSel;
  logic       timerClear, timerMatch;
  logic       pressEv, releaseEv;
  logic       shortNext, doubleNext, longNext, repeatNext, heldNext;
  logic       shortQ, doubleQ, longQ, repeatQ, heldQ;

  // Press and release together cancel each other.
  assign pressEv   = bus.press_pulse & ~bus.release_pulse;
  assign releaseEv = bus.release_pulse & ~bus.press_pulse;

  // Timer limit follows the interval that matters in the current state.
  always_comb begin
    timerSel = SEL_LONG;
    case (state)
      LONG_HELD: timerSel = SEL_REPEAT;
      WAIT_GAP:  timerSel = SEL_GAP;
      default:   timerSel = SEL_LONG;
    endcase
  end

  event_timer #(
    .CW       (CW),
    .LONG_TC  (LONG_TC),
    .REPEAT_TC(REPEAT_TC),
    .GAP_TC   (GAP_TC)
  ) uTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timerClear),
    .load    (1'b0),
    .loadVal ({CW{1'b0}}),
    .limitSel(timerSel),
    .match   (timerMatch)
  );

  // Next-state and next-event decode.
  always_comb begin
    stateNext  = state;
    timerClear = 1'b0;
    shortNext  = 1'b0;
    doubleNext = 1'b0;
    longNext   = 1'b0;
    repeatNext = 1'b0;
    case (state)
      IDLE: begin
        timerClear = 1'b1;
        if (pressEv) stateNext = PRESSED;
      end
      PRESSED: begin
        if (releaseEv) begin
          if (GAP_CYCLES == 0) begin
            shortNext = 1'b1;
            stateNext = IDLE;
          end else begin
            stateNext = WAIT_GAP;
          end
        end else if (timerMatch) begin
          longNext  = 1'b1;
          stateNext = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (releaseEv) begin
          stateNext = IDLE;
        end else if (timerMatch) begin
          repeatNext = 1'b1;
          timerClear = 1'b1;
        end
      end
      WAIT_GAP: begin
        // Timeout beats a press arriving on the same cycle.
        if (timerMatch) begin
          shortNext = 1'b1;
          stateNext = IDLE;
        end else if (pressEv) begin
          stateNext = SECOND_PRESSED;
        end
      end
      SECOND_PRESSED: begin
        if (releaseEv) begin
          doubleNext = 1'b1;
          stateNext  = IDLE;
        end else if (timerMatch) begin
          shortNext = 1'b1;
          longNext  = 1'b1;
          stateNext = LONG_HELD;
        end
      end
      default: begin
        stateNext  = IDLE;
        timerClear = 1'b1;
      end
    endcase
    if (stateNext != state) timerClear = 1'b1;
    heldNext = (stateNext == PRESSED) || (stateNext == LONG_HELD) ||
               (stateNext == SECOND_PRESSED);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shortQ  <= 1'b0;
      doubleQ <= 1'b0;
      longQ   <= 1'b0;
      repeatQ <= 1'b0;
      heldQ   <= 1'b0;
    end else begin
      shortQ  <= shortNext;
      doubleQ <= doubleNext;
      longQ   <= longNext;
      repeatQ <= repeatNext;
      heldQ   <= heldNext;
    end
  end

  assign bus.short_pulse  = shortQ;
  assign bus.double_pulse = doubleQ;
  assign bus.long_pulse   = longQ;
  assign bus.repeat_pulse = repeatQ;
  assign bus.held         = heldQ;

endmodule

// File: tb/tb_button_press_classifier.sv
// Drives two classifiers (gap 8 and gap 0) with the same pulse stream and
// compares every cycle against a timestamp-based reference model.
module tb_button_press_classifier;

  localparam int L = 20;
  localparam int R = 5;
  localparam int G = 8;

  logic clk;
  logic rst_n;
  int   nCompared;
  int   nMismatched;
  int   now;

  button_press_classifier_if ifA ();
  button_press_classifier_if ifB ();

  button_press_classifier #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .GAP_CYCLES(G)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA)
  );
  button_press_classifier #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .GAP_CYCLES(0)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, whether the button is down, whether a
  // long hold has been reported, whether a released click is pending, and
  // the cycle stamps those conditions started at.
  bit       down    [2];
  bit       isLong  [2];
  bit       waiting [2];
  bit       second  [2];
  int       downAt  [2];
  int       upAt    [2];
  int       lastRep [2];
  logic [4:0] expv  [2];   // {held, short, double, long, repeat}

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", tag, now, obs, exp);
    end
  endtask

  function automatic logic [4:0] obsA();
    return {ifA.held, ifA.short_pulse, ifA.double_pulse, ifA.long_pulse, ifA.repeat_pulse};
  endfunction

  function automatic logic [4:0] obsB();
    return {ifB.held, ifB.short_pulse, ifB.double_pulse, ifB.long_pulse, ifB.repeat_pulse};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      down[i] = 0; isLong[i] = 0; waiting[i] = 0; second[i] = 0;
      downAt[i] = 0; upAt[i] = 0; lastRep[i] = 0; expv[i] = '0;
    end
  endtask

  task automatic checkOutputs(input string tag);
    checkVal({tag, "_gap8"}, {3'b0, obsA()}, {3'b0, expv[0]});
    checkVal({tag, "_gap0"}, {3'b0, obsB()}, {3'b0, expv[1]});
  endtask

  // Apply inputs for the coming rising edge and advance the model over it.
  task automatic driveAndModel(input bit p, input bit r);
    bit pe, re, s, d, lg, rp;
    int gap;
    ifA.press_pulse = p; ifA.release_pulse = r;
    ifB.press_pulse = p; ifB.release_pulse = r;
    pe = p & ~r;
    re = r & ~p;
    now++;
    for (int i = 0; i < 2; i++) begin
      gap = (i == 0) ? G : 0;
      s = 0; d = 0; lg = 0; rp = 0;
      if (waiting[i]) begin
        if (now - upAt[i] == gap) begin
          s = 1; waiting[i] = 0;
        end else if (pe) begin
          waiting[i] = 0; down[i] = 1; second[i] = 1; downAt[i] = now;
        end
      end else if (down[i] && isLong[i]) begin
        if (re) begin
          down[i] = 0; isLong[i] = 0;
        end else if (now - lastRep[i] == R) begin
          rp = 1; lastRep[i] = now;
        end
      end else if (down[i]) begin
        if (re) begin
          down[i] = 0;
          if (second[i])     d = 1;
          else if (gap == 0) s = 1;
          else begin waiting[i] = 1; upAt[i] = now; end
        end else if (now - downAt[i] == L) begin
          lg = 1; isLong[i] = 1; lastRep[i] = now;
          if (second[i]) s = 1;
        end
      end else if (pe) begin
        down[i] = 1; second[i] = 0; downAt[i] = now;
      end
      expv[i] = {down[i], s, d, lg, rp};
    end
  endtask

  task automatic stepCycle(input bit p, input bit r);
    @(negedge clk);
    checkOutputs("cyc");
    driveAndModel(p, r);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) stepCycle(0, 0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    checkOutputs("pre_rst");
    ifA.press_pulse = 0; ifA.release_pulse = 0;
    ifB.press_pulse = 0; ifB.release_pulse = 0;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutputs("rst_now");
    @(negedge clk);
    checkOutputs("rst_hold");
    rst_n = 1'b1;
    driveAndModel(0, 0);
  endtask

  task automatic noisyStep();
    int k;
    k = $urandom_range(0, 31);
    if (k == 0)      stepCycle(1, 1);
    else if (k == 1) stepCycle(1, 0);
    else if (k == 2) stepCycle(0, 1);
    else             stepCycle(0, 0);
  endtask

  task automatic gesture(input int holdLen, input int gapLen);
    stepCycle(1, 0);
    for (int k = 0; k < holdLen - 1; k++) noisyStep();
    stepCycle(0, 1);
    for (int k = 0; k < gapLen; k++) noisyStep();
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    now = 0;
    rst_n = 1'b0;
    ifA.press_pulse = 0; ifA.release_pulse = 0;
    ifB.press_pulse = 0; ifB.release_pulse = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutputs("reset");
    rst_n = 1'b1;
    driveAndModel(0, 0);

    // Short press: held 5 cycles, short reported after the gap.
    stepCycle(1, 0); idle(4); stepCycle(0, 1); idle(12);
    // Double press.
    stepCycle(1, 0); idle(3); stepCycle(0, 1); idle(2);
    stepCycle(1, 0); idle(3); stepCycle(0, 1); idle(12);
    // Long hold with repeats, then release.
    stepCycle(1, 0); idle(31); stepCycle(0, 1); idle(12);
    // Click then long second press: short and long together.
    stepCycle(1, 0); idle(3); stepCycle(0, 1); idle(2);
    stepCycle(1, 0); idle(30); stepCycle(0, 1); idle(12);
    // Second press on the last gap cycle is accepted; one later is dropped.
    stepCycle(1, 0); idle(2); stepCycle(0, 1); idle(G - 2);
    stepCycle(1, 0); idle(2); stepCycle(0, 1); idle(12);
    stepCycle(1, 0); idle(2); stepCycle(0, 1); idle(G - 1);
    stepCycle(1, 0); idle(2); stepCycle(0, 1); idle(12);
    // Reset during LONG_HELD, then release: nothing reported.
    stepCycle(1, 0); idle(24); applyReset(); stepCycle(0, 1); idle(12);
    // Reset during WAIT_GAP.
    stepCycle(1, 0); idle(3); stepCycle(0, 1); idle(3); applyReset(); idle(12);
    // Simultaneous press and release in IDLE.
    stepCycle(1, 1); idle(25);
    // Release on the long terminal cycle.
    stepCycle(1, 0); idle(L - 2); stepCycle(0, 1); idle(12);

    for (int g = 0; g < 160; g++) begin
      if ($urandom_range(0, 14) == 0) applyReset();
      gesture($urandom_range(1, 36), $urandom_range(1, 12));
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
